// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider / tick generator with a valid/ready config port.
// New period/high-time settings are held in a shadow and applied only at a period boundary.
module prog_clock_divider #(
    parameter int CNT_W          = 27,
    parameter int DEFAULT_PERIOD = 100_000_000,
    parameter int DEFAULT_HIGH   = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             slow_clk,
    output logic             tick,
    output logic             cfg_pending
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mode_t;

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] RST_HIGH   = CNT_W'(DEFAULT_HIGH);
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO       = CNT_W'(0);

    mode_t            mode_r, mode_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] period_r, period_s, high_r, high_s;
    logic [CNT_W-1:0] shadow_period_r, shadow_period_s, shadow_high_r, shadow_high_s;
    logic             pending_r, pending_s;
    logic             slow_clk_r, slow_clk_s, tick_r, tick_s;
    logic             apply_s, take_s;

    // Next-state: mode/counter sequencing, boundary apply, handshake capture, output decode.
    always_comb begin
        mode_s          = mode_r;
        cnt_s           = cnt_r;
        apply_s         = 1'b0;
        take_s          = cfg_valid && !pending_r;
        period_s        = period_r;
        high_s          = high_r;
        shadow_period_s = shadow_period_r;
        shadow_high_s   = shadow_high_r;
        pending_s       = pending_r;

        case (mode_r)
            IDLE: begin
                apply_s = pending_r;
                cnt_s   = ZERO;
                if (en) begin
                    mode_s = RUN;
                end else begin
                    mode_s = IDLE;
                end
            end
            RUN: begin
                if (!en) begin
                    // Abandon the period; any pending config is applied once idle.
                    mode_s = IDLE;
                    cnt_s  = ZERO;
                end else if (cnt_r == period_r - ONE) begin
                    cnt_s   = ZERO;
                    apply_s = pending_r;
                end else begin
                    cnt_s = cnt_r + ONE;
                end
            end
            default: begin
                mode_s = IDLE;
                cnt_s  = ZERO;
            end
        endcase

        // apply and take are mutually exclusive: take needs !pending, apply needs pending.
        if (apply_s) begin
            period_s  = shadow_period_r;
            high_s    = shadow_high_r;
            pending_s = 1'b0;
        end else if (take_s) begin
            shadow_period_s = (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;
            shadow_high_s   = cfg_high;
            pending_s       = 1'b1;
        end else begin
            pending_s = pending_r;
        end

        slow_clk_s = (mode_s == RUN) && (cnt_s < high_s);
        tick_s     = (mode_s == RUN) && (cnt_s == ZERO);
    end

    // State and output registers; reset discards any shadow config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r          <= IDLE;
            cnt_r           <= ZERO;
            period_r        <= RST_PERIOD;
            high_r          <= RST_HIGH;
            shadow_period_r <= RST_PERIOD;
            shadow_high_r   <= RST_HIGH;
            pending_r       <= 1'b0;
            slow_clk_r      <= 1'b0;
            tick_r          <= 1'b0;
        end else begin
            mode_r          <= mode_s;
            cnt_r           <= cnt_s;
            period_r        <= period_s;
            high_r          <= high_s;
            shadow_period_r <= shadow_period_s;
            shadow_high_r   <= shadow_high_s;
            pending_r       <= pending_s;
            slow_clk_r      <= slow_clk_s;
            tick_r          <= tick_s;
        end
    end

    assign slow_clk    = slow_clk_r;
    assign tick        = tick_r;
    assign cfg_pending = pending_r;
    assign cfg_ready   = !pending_r;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: directed plan steps plus random traffic
// compared every cycle against a cycle-position model of the divider.
module tb_prog_clock_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic         slow_clk;
    logic         tick;
    logic         cfg_pending;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the current period and the settings in force.
    bit m_run;
    int m_pos;
    int m_per, m_high;
    int m_sper, m_shigh;
    bit m_pend;

    prog_clock_divider #(
        .CNT_W(W),
        .DEFAULT_PERIOD(10),
        .DEFAULT_HIGH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_period(cfg_period),
        .cfg_high(cfg_high),
        .slow_clk(slow_clk),
        .tick(tick),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_per  = 10;
        m_high = 5;
        m_pend = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit v, input int p, input int h);
        bit take;
        bit apply;
        take  = v && !m_pend;
        apply = 1'b0;
        if (!m_run) begin
            apply = m_pend;
            if (e) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (!e) begin
            m_run = 1'b0;
            m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % m_per;
            if (m_pos == 0) apply = m_pend;
        end
        if (apply) begin
            m_per  = m_sper;
            m_high = m_shigh;
            m_pend = 1'b0;
        end else if (take) begin
            m_sper  = (p < 2) ? 2 : p;
            m_shigh = h;
            m_pend  = 1'b1;
        end
    endtask

    // One clock: capture inputs, advance the model on the edge, compare just after it.
    task automatic cycle();
        bit e;
        bit v;
        int p;
        int h;
        e = en;
        v = cfg_valid;
        p = int'(cfg_period);
        h = int'(cfg_high);
        @(posedge clk);
        model_edge(e, v, p, h);
        #1;
        chk("slow_clk", slow_clk, m_run && (m_pos < m_high));
        chk("tick", tick, m_run && (m_pos == 0));
        chk("cfg_ready", cfg_ready, !m_pend);
        chk("cfg_pending", cfg_pending, m_pend);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_pos(input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (m_run && m_pos == p) hit = 1'b1;
            else cycle();
        end
        if (!hit) begin
            checks++;
            failures++;
            $error("FAIL wait_pos observed=timeout expected=pos%0d", p);
        end
    endtask

    // Offer a config and hold it until the handshake completes.
    task automatic offer(input int p, input int h);
        bit acc;
        bit done;
        done       = 1'b0;
        cfg_valid  = 1'b1;
        cfg_period = W'(p);
        cfg_high   = W'(h);
        for (int i = 0; i < 300 && !done; i++) begin
            acc = !m_pend;
            cycle();
            if (acc) done = 1'b1;
        end
        cfg_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL offer observed=timeout expected=accept");
        end
    endtask

    initial begin
        bit vr;
        rst        = 1'b1;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        model_reset();
        #22;
        chk("rst_slow", slow_clk, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_ready", cfg_ready, 1'b1);
        chk("rst_pending", cfg_pending, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Default 10/5 waveform
        en = 1'b1;
        run(25);

        // Reconfigure at cnt 3 to 4/1; old period completes first
        wait_pos(3);
        offer(4, 1);
        run(20);

        // Sanitised period, constant-low, constant-high
        offer(1, 1);
        run(10);
        offer(6, 0);
        run(20);
        offer(6, 20);
        run(20);

        // Stop mid-period and restart
        offer(10, 5);
        run(15);
        wait_pos(6);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(12);

        // Back-to-back configs: second waits for the first to apply
        offer(5, 2);
        offer(7, 3);
        run(25);

        // Asynchronous reset with a config pending and slow_clk high
        offer(10, 5);
        run(25);
        wait_pos(1);
        offer(3, 1);
        chk("pre_rst_pending", cfg_pending, 1'b1);
        chk("pre_rst_slow", slow_clk, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_slow", slow_clk, 1'b0);
        chk("async_tick", tick, 1'b0);
        chk("async_pending", cfg_pending, 1'b0);
        chk("async_ready", cfg_ready, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(25);

        // Random traffic: source holds valid/data until accepted
        for (int i = 0; i < 800; i++) begin
            en = ($urandom_range(0, 15) != 0);
            if (!cfg_valid && $urandom_range(0, 9) == 0) begin
                cfg_valid  = 1'b1;
                cfg_period = W'($urandom_range(0, 16));
                cfg_high   = W'($urandom_range(0, 20));
            end
            vr = cfg_valid && !m_pend;
            cycle();
            if (vr) cfg_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
